// File: rtl/gcd_arbiter_if.sv
// gcd_arbiter_if -- requester-side bus of the GCD arbiter.
//
// Four requesters share one GCD core. Requester i packs its operands in
// req_a/req_b bits [i*WIDTH +: WIDTH].
//   req_valid  per-requester request pending
//   req_a/b    packed operands
//   req_ready  one-hot, one-cycle grant pulse
//   rsp_valid  one-hot, result held for the owning requester
//   rsp_data   GCD result
//   rsp_ack    per-requester response consume
// Modports: master = requester side, slave = arbiter side.
interface gcd_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req_valid;
    logic [4*WIDTH-1:0] req_a;
    logic [4*WIDTH-1:0] req_b;
    logic [3:0]         req_ready;
    logic [3:0]         rsp_valid;
    logic [WIDTH-1:0]   rsp_data;
    logic [3:0]         rsp_ack;

    modport master (
        output req_valid, req_a, req_b, rsp_ack,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ack,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/gcd_arbiter.sv
// gcd_arbiter -- round-robin arbiter sharing one GCD core among 4 requesters.
//
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   bus (slave)             requester bus (see gcd_arbiter_if)
//   gcd_operand_A/B         operands to the core, held from ISSUE to end of WAIT
//   gcd_input_available     core idle
//   gcd_input_ready         one-cycle pulse starting the core
//   gcd_result_rdy/data     core result valid/value
//   gcd_result_taken        one-cycle pulse releasing the core result
//   busy                    high whenever not IDLE
//   done_cnt                completed transactions (wraps)
//
// Optional feature: define GCD_ARB_ZERO_BYPASS_EN to answer requests with a
// zero operand directly (result = a | b) without using the core.
module gcd_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    gcd_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] gcd_operand_A,
    output logic [WIDTH-1:0] gcd_operand_B,
    input  logic             gcd_input_available,
    output logic             gcd_input_ready,
    input  logic             gcd_result_rdy,
    input  logic [WIDTH-1:0] gcd_result_data,
    output logic             gcd_result_taken,
    output logic             busy,
    output logic [15:0]      done_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic [1:0] owner;
    logic [1:0] rr_ptr;

    // Round-robin pick: scan offsets 3..0 from rr_ptr so the lowest
    // offset with a pending request is the last (winning) assignment.
    logic             win_any;
    logic [1:0]       win_idx;
    logic [1:0]       cand;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             grant_ok;

    always_comb begin
        win_any = 1'b0;
        win_idx = rr_ptr;
        cand    = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr + 2'(k);
            if (bus.req_valid[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign win_a = bus.req_a[win_idx*WIDTH +: WIDTH];
    assign win_b = bus.req_b[win_idx*WIDTH +: WIDTH];

`ifdef GCD_ARB_ZERO_BYPASS_EN
    logic win_zero;
    assign win_zero = (win_a == '0) || (win_b == '0);
    // A zero-operand winner never touches the core, so it need not wait
    // for the core to be available.
    assign grant_ok = win_any && (gcd_input_available || win_zero);
`else
    assign grant_ok = win_any && gcd_input_available;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state            <= IDLE;
            owner            <= '0;
            rr_ptr           <= '0;
            done_cnt         <= '0;
            busy             <= 1'b0;
            bus.req_ready    <= '0;
            bus.rsp_valid    <= '0;
            bus.rsp_data     <= '0;
            gcd_operand_A    <= '0;
            gcd_operand_B    <= '0;
            gcd_input_ready  <= 1'b0;
            gcd_result_taken <= 1'b0;
        end else begin
            // Pulses default low; each is raised for exactly one cycle below.
            bus.req_ready    <= '0;
            gcd_input_ready  <= 1'b0;
            gcd_result_taken <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        owner         <= win_idx;
                        bus.req_ready <= 4'b0001 << win_idx;
                        busy          <= 1'b1;
`ifdef GCD_ARB_ZERO_BYPASS_EN
                        if (win_zero) begin
                            bus.rsp_data  <= win_a | win_b;
                            bus.rsp_valid <= 4'b0001 << win_idx;
                            state         <= RESP;
                        end else begin
                            gcd_operand_A <= win_a;
                            gcd_operand_B <= win_b;
                            state         <= ISSUE;
                        end
`else
                        gcd_operand_A <= win_a;
                        gcd_operand_B <= win_b;
                        state         <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    gcd_input_ready <= 1'b1;
                    state           <= WAIT;
                end
                WAIT: begin
                    if (gcd_result_rdy) begin
                        bus.rsp_data     <= gcd_result_data;
                        bus.rsp_valid    <= 4'b0001 << owner;
                        gcd_result_taken <= 1'b1;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ack[owner]) begin
                        bus.rsp_valid <= '0;
                        rr_ptr        <= owner + 2'd1;
                        done_cnt      <= done_cnt + 16'd1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter -- directed, table-driven bench for gcd_arbiter with a
// behavioral multi-cycle GCD core model.
module tb_gcd_arbiter;
    localparam int W = 8;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    always #5 sys_clk = ~sys_clk;

    gcd_arbiter_if #(.WIDTH(W)) bus ();

    logic [W-1:0] gcd_operand_A, gcd_operand_B;
    logic [W-1:0] gcd_result_data = '0;
    logic         gcd_input_available, gcd_input_ready, gcd_result_taken, busy;
    logic         gcd_result_rdy = 1'b0;
    logic [15:0]  done_cnt;
    logic         avail_en = 1'b1;

    gcd_arbiter #(.WIDTH(W)) dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
        .bus                 (bus),
        .gcd_operand_A       (gcd_operand_A),
        .gcd_operand_B       (gcd_operand_B),
        .gcd_input_available (gcd_input_available),
        .gcd_input_ready     (gcd_input_ready),
        .gcd_result_rdy      (gcd_result_rdy),
        .gcd_result_data     (gcd_result_data),
        .gcd_result_taken    (gcd_result_taken),
        .busy                (busy),
        .done_cnt            (done_cnt)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[8];

    int checks = 0;
    int errors = 0;

    // Core model / monitor state
    bit           core_busy = 1'b0;
    int           core_cnt = 0;
    logic [W-1:0] ca, cb;
    int cyc = 0, ngrant = 0, in_rdy_cnt = 0, in_rdy_cyc = 0, rdy_cyc = 0;
    int grant_cyc = 0, rsp_rise_cnt = 0, rsp_cyc = 0;
    int grant_log[64];
    logic [3:0] prev_rsp = '0;

    assign gcd_input_available = avail_en && !core_busy;

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Monitor + 3-cycle core model, all sampled on the falling edge.
    always @(negedge sys_clk) begin
        cyc++;
        if (bus.req_ready != 0) begin
            for (int i = 0; i < 4; i++)
                if (bus.req_ready[i]) grant_log[ngrant % 64] = i;
            ngrant++;
            grant_cyc = cyc;
        end
        if (gcd_input_ready) begin
            in_rdy_cnt++;
            in_rdy_cyc = cyc;
        end
        if (bus.rsp_valid != 0 && prev_rsp == 0) begin
            rsp_rise_cnt++;
            rsp_cyc = cyc;
        end
        prev_rsp = bus.rsp_valid;

        if (sys_rst) begin
            core_busy      = 1'b0;
            core_cnt       = 0;
            gcd_result_rdy = 1'b0;
        end else if (gcd_result_taken) begin
            gcd_result_rdy = 1'b0;
            core_busy      = 1'b0;
        end else if (gcd_input_ready && !core_busy) begin
            core_busy = 1'b1;
            core_cnt  = 3;
            ca        = gcd_operand_A;
            cb        = gcd_operand_B;
        end else if (core_busy && core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                gcd_result_rdy  = 1'b1;
                gcd_result_data = gcd_f(ca, cb);
                rdy_cyc         = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge sys_clk);
        #1;
    endtask

    task automatic wait_rsp;
        int k;
        k = 0;
        while (bus.rsp_valid == 0 && k < 50) begin
            tick();
            k++;
        end
        chk("rsp_timeout", 32'(k < 50), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 0);
        chk({tag, "_opA"}, gcd_operand_A, 0);
        chk({tag, "_opB"}, gcd_operand_B, 0);
        chk({tag, "_in_ready"}, gcd_input_ready, 0);
        chk({tag, "_taken"}, gcd_result_taken, 0);
        chk({tag, "_done_cnt"}, done_cnt, 0);
    endtask

    task automatic run_txn(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e, input int exp_core);
        int g0, c0, d0, k;
        g0 = ngrant;
        c0 = in_rdy_cnt;
        d0 = int'(done_cnt);
        bus.req_a[r*W +: W] = a;
        bus.req_b[r*W +: W] = b;
        bus.req_valid[r]    = 1'b1;
        k = 0;
        while (ngrant == g0 && k < 50) begin
            tick();
            k++;
        end
        chk("grant_seen", 32'(ngrant > g0), 1);
        // Withdraw and corrupt the request right after the grant.
        bus.req_valid[r]    = 1'b0;
        bus.req_a[r*W +: W] = 8'hFF;
        bus.req_b[r*W +: W] = 8'hFF;
        chk("grant_owner", grant_log[g0 % 64], r);
        wait_rsp();
        chk("rsp_onehot", bus.rsp_valid, 32'(1) << r);
        chk("rsp_data", bus.rsp_data, e);
        chk("core_starts", in_rdy_cnt - c0, exp_core);
        if (exp_core == 1) begin
            chk("issue_latency", in_rdy_cyc - grant_cyc, 1);
            chk("rsp_latency", rsp_cyc - rdy_cyc, 1);
        end
        bus.rsp_ack = 4'b0001 << r;
        tick();
        bus.rsp_ack = '0;
        chk("rsp_cleared", bus.rsp_valid, 0);
        chk("busy_after_ack", busy, 0);
        chk("done_cnt", done_cnt, 16'(d0 + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, k, c0, r0, ec;
        logic [3:0]   hv;
        logic [W-1:0] hd;
        bit           stable;

        vecs[0] = '{a: 8'd24,  b: 8'd18, exp: 8'd6};
        vecs[1] = '{a: 8'd105, b: 8'd99, exp: 8'd3};
        vecs[2] = '{a: 8'd36,  b: 8'd8,  exp: 8'd4};
        vecs[3] = '{a: 8'd66,  b: 8'd18, exp: 8'd6};
        vecs[4] = '{a: 8'd0,   b: 8'd15, exp: 8'd15};
        vecs[5] = '{a: 8'd17,  b: 8'd5,  exp: 8'd1};
        vecs[6] = '{a: 8'd255, b: 8'd51, exp: 8'd51};
        vecs[7] = '{a: 8'd7,   b: 8'd7,  exp: 8'd7};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ack   = '0;
        #2 sys_rst = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        sys_rst = 1'b0;
        tick();

        // Single-requester transactions from the table.
        for (int i = 0; i < 8; i++) begin
            ec = 1;
`ifdef GCD_ARB_ZERO_BYPASS_EN
            if (vecs[i].a == 0 || vecs[i].b == 0) ec = 0;
`endif
            run_txn(i % 4, vecs[i].a, vecs[i].b, vecs[i].exp, ec);
        end

        // All four requesters held valid: rotation 0,1,2,3,0.
        for (int j = 0; j < 4; j++) begin
            bus.req_a[j*W +: W] = vecs[j].a;
            bus.req_b[j*W +: W] = vecs[j].b;
        end
        g0 = ngrant;
        bus.req_valid = 4'hF;
        for (int j = 0; j < 4; j++) begin
            wait_rsp();
            chk("rr_order", grant_log[(g0 + j) % 64], j);
            chk("rr_rsp_onehot", bus.rsp_valid, 32'(1) << j);
            chk("rr_rsp_data", bus.rsp_data, vecs[j].exp);
            bus.rsp_ack = 4'b0001 << j;
            tick();
            bus.rsp_ack = '0;
        end
        wait_rsp();
        chk("rr_wrap_owner", grant_log[(g0 + 4) % 64], 0);
        chk("rr_wrap_data", bus.rsp_data, vecs[0].exp);

        // Withhold the owner's ack for 10 cycles; non-owner acks must be ignored.
        hv = bus.rsp_valid;
        hd = bus.rsp_data;
        k  = ngrant;
        stable = 1'b1;
        bus.rsp_ack = 4'b1110;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (bus.rsp_valid !== hv || bus.rsp_data !== hd) stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 1);
        chk("hold_no_grant", ngrant - k, 0);
        bus.req_valid = '0;
        bus.rsp_ack   = 4'b0001;
        tick();
        bus.rsp_ack   = '0;
        chk("hold_release", bus.rsp_valid, 0);

        // Core unavailable: no grant, stays idle.
        avail_en = 1'b0;
        bus.req_a[2*W +: W] = 8'd36;
        bus.req_b[2*W +: W] = 8'd8;
        bus.req_valid[2]    = 1'b1;
        g0 = ngrant;
        repeat (6) tick();
        chk("unavail_no_grant", ngrant - g0, 0);
        chk("unavail_busy", busy, 0);
        avail_en = 1'b1;
        run_txn(2, 8'd36, 8'd8, 8'd4, 1);

        // Reset while waiting on the core.
        c0 = in_rdy_cnt;
        bus.req_a[1*W +: W] = 8'd24;
        bus.req_b[1*W +: W] = 8'd18;
        bus.req_valid[1]    = 1'b1;
        k = 0;
        while (in_rdy_cnt == c0 && k < 50) begin
            tick();
            k++;
        end
        chk("pre_rst_issue", 32'(in_rdy_cnt > c0), 1);
        bus.req_valid = '0;
        tick();
        chk("pre_rst_busy", busy, 1);
        r0 = rsp_rise_cnt;
        sys_rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        sys_rst = 1'b0;
        repeat (8) tick();
        chk("midrst_no_rsp", rsp_rise_cnt - r0, 0);

        // rr_ptr back at 0: with 1 and 3 pending, 1 wins first.
        bus.req_a[1*W +: W] = vecs[1].a;
        bus.req_b[1*W +: W] = vecs[1].b;
        bus.req_a[3*W +: W] = vecs[3].a;
        bus.req_b[3*W +: W] = vecs[3].b;
        bus.req_valid = 4'b1010;
        wait_rsp();
        chk("post_rst_first", bus.rsp_valid, 4'b0010);
        chk("post_rst_data1", bus.rsp_data, vecs[1].exp);
        bus.req_valid[1] = 1'b0;
        bus.rsp_ack = 4'b0010;
        tick();
        bus.rsp_ack = '0;
        wait_rsp();
        chk("post_rst_second", bus.rsp_valid, 4'b1000);
        chk("post_rst_data3", bus.rsp_data, vecs[3].exp);
        bus.req_valid = '0;
        bus.rsp_ack = 4'b1000;
        tick();
        bus.rsp_ack = '0;
        chk("post_rst_done_cnt", done_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result bit width.
REQ-002 SHALL have port sys_clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  4  per-requester request pending.
REQ-005 SHALL have port req_a  input  4*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port req_b  input  4*WIDTH  operand B, same packing.
REQ-007 SHALL have port req_ready  output  4  one-hot, one-cycle grant pulse; operands captured that cycle.
REQ-008 SHALL have port rsp_valid  output  4  one-hot, result available for owner.
REQ-009 SHALL have port rsp_data  output  WIDTH  GCD result.
REQ-010 SHALL have port rsp_ack  input  4  per-requester response consume.
REQ-011 SHALL have ports gcd_operand_A, gcd_operand_B  output  WIDTH each  operands to the GCD core.
REQ-012 SHALL have port gcd_input_available  input  1  core idle, can accept operands.
REQ-013 SHALL have port gcd_input_ready  output  1  one-cycle pulse starting a core computation.
REQ-014 SHALL have ports gcd_result_rdy (input 1) and gcd_result_data (input WIDTH)  core result valid/value.
REQ-015 SHALL have port gcd_result_taken  output  1  one-cycle pulse releasing the core result.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port done_cnt  output  16  completed transactions, wraps 0xFFFF->0.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: when any req_valid=1 and gcd_input_available=1, SHALL select the winner round-robin starting at rr_ptr, latch its operands and owner index, pulse req_ready[owner], go ISSUE.
REQ-020 ISSUE: SHALL hold gcd_operand_A/B at latched values and pulse gcd_input_ready for exactly one cycle, go WAIT.
REQ-021 WAIT: on gcd_result_rdy=1 SHALL latch gcd_result_data into rsp_data, pulse gcd_result_taken one cycle, go RESP.
REQ-022 RESP: SHALL hold rsp_valid[owner]=1 and rsp_data stable until rsp_ack[owner]=1; then set rr_ptr=(owner+1) mod 4, increment done_cnt, go IDLE.
REQ-023 gcd_operand_A/B SHALL remain stable from ISSUE until leaving WAIT.
REQ-024 gcd_result_rdy in IDLE/ISSUE/RESP SHALL be ignored; rsp_ack on non-owner bits SHALL be ignored.
REQ-025 req_valid deasserted after grant SHALL NOT affect the transaction.
REQ-026 With all four requesters valid continuously, grants SHALL rotate 0,1,2,3,0 from reset.
REQ-027 Grant-to-gcd_input_ready latency SHALL be exactly 1 cycle; result_rdy-to-rsp_valid latency exactly 1 cycle.

Reset
REQ-028 sys_rst=1 SHALL immediately force IDLE, rr_ptr=0, done_cnt=0, all outputs 0 (req_ready, rsp_valid, rsp_data, gcd_operand_A/B, gcd_input_ready, gcd_result_taken, busy).
REQ-029 Reset mid-transaction SHALL abandon it with no response; core reset is outside this block.

Configuration
REQ-030 With macro GCD_ARB_ZERO_BYPASS_EN defined, a winner with req_a=0 or req_b=0 SHALL skip ISSUE/WAIT, go directly to RESP with rsp_data=req_a|req_b, granted without requiring gcd_input_available and with no core handshake.
REQ-031 Without GCD_ARB_ZERO_BYPASS_EN, zero operands SHALL be dispatched to the core like any other request.

Verification
REQ-032 Requester 0: a=24, b=18, core model -> one req_ready[0] pulse, one gcd_input_ready pulse, rsp_valid[0] with rsp_data=6, done_cnt=1.
REQ-033 Requesters 0..3 all valid (24/18, 105/99, 36/8, 66/18) -> grants in order 0,1,2,3; rsp_data 6,3,4,6.
REQ-034 gcd_input_available=0 with req_valid[2]=1 -> no grant, busy=0 until available rises.
REQ-035 sys_rst pulsed in WAIT -> next cycle busy=0, all outputs 0, rr_ptr=0, no rsp_valid.
REQ-036 GCD_ARB_ZERO_BYPASS_EN defined, a=0, b=15 -> no gcd_input_ready pulse, rsp_data=15 one cycle after grant; undefined -> core handshake occurs.
REQ-037 rsp_ack held low 10 cycles in RESP -> rsp_valid/rsp_data stable, no new grant.
